// File: rtl/iob_native2iob_pkg.sv
// Shared types and constants for the native-to-IOb bridge.
package iob_native2iob_pkg;

    // Bridge FSM encoding, also exported on the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Read word returned to the CPU when an access is aborted.
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

    // Channel index width; a single channel still needs a 1-bit index.
    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/iob_bridge_timeout.sv
// Access timeout counter: cleared while idle, counts cycles spent in an
// access, and flags expiry on the cycle the count would reach TIMEOUT.
module iob_bridge_timeout #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cke,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            // Timeout disabled: never expires.
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] count;

            // Count access cycles; hold once expired so the value cannot wrap.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (cke) begin
                    if (clr) begin
                        count <= '0;
                    end else if (en && !expired) begin
                        count <= count + 1'b1;
                    end
                end
            end

            assign expired = en && (count >= LIMIT);
        end
    endgenerate

endmodule

// File: rtl/iob_native2iob_bridge.sv
// Bridge from a single-outstanding native valid/ready port to N_CH IOb
// channels selected by the top address bits, with timeout and error word.
//
// Handshakes: the CPU holds native_valid_i until it sees a one-cycle
// native_ready_o pulse. Each IOb channel sees avalid held until it answers
// with ready (address phase); reads then wait for rvalid on the same channel
// (data phase). Inputs of unselected channels are never looked at.
module iob_native2iob_bridge
    import iob_native2iob_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_CH = 2,
    parameter int TIMEOUT = 1023,
    parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_RDATA_DEFAULT)
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic                   cke_i,
    input  logic                   native_valid_i,
    input  logic [ADDR_W-1:0]      native_addr_i,
    input  logic [DATA_W-1:0]      native_wdata_i,
    input  logic [DATA_W/8-1:0]    native_wstrb_i,
    output logic [DATA_W-1:0]      native_rdata_o,
    output logic                   native_ready_o,
    output logic                   err_o,
    output logic [N_CH-1:0]        iob_avalid_o,
    output logic [ADDR_W-1:0]      iob_addr_o,
    output logic [DATA_W-1:0]      iob_wdata_o,
    output logic [DATA_W/8-1:0]    iob_wstrb_o,
    input  logic [N_CH-1:0]        iob_ready_i,
    input  logic [N_CH-1:0]        iob_rvalid_i,
    input  logic [N_CH*DATA_W-1:0] iob_rdata_i,
    output logic [1:0]             state_o
);

    localparam int CH_W = ch_width(N_CH);

    state_t            state;
    logic [CH_W-1:0]   ch_q;
    logic [CH_W-1:0]   addr_ch;
    logic              bad_ch;
    logic [N_CH-1:0]   addr_onehot;
    logic              sel_ready;
    logic              sel_rvalid;
    logic [DATA_W-1:0] sel_rdata;
    logic              in_access;
    logic              tmo_clr;
    logic              expired;

    // Channel number from the top address bits; one channel always maps to 0.
    generate
        if (N_CH > 1) begin : g_dec
            assign addr_ch = native_addr_i[ADDR_W-1 -: CH_W];
        end else begin : g_single
            assign addr_ch = '0;
        end
    endgenerate

    assign bad_ch = (int'(addr_ch) >= N_CH);

    // One-hot avalid pattern for the incoming request's channel.
    always_comb begin
        addr_onehot = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (addr_ch == CH_W'(k)) begin
                addr_onehot[k] = 1'b1;
            end
        end
    end

    // Select the latched channel's ready/rvalid/rdata.
    always_comb begin
        sel_ready  = 1'b0;
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
                sel_ready  = iob_ready_i[k];
                sel_rvalid = iob_rvalid_i[k];
                sel_rdata  = iob_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign in_access = (state == ST_REQ) || (state == ST_RESP);
    assign tmo_clr   = (state == ST_IDLE);

    iob_bridge_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk_i),
        .rst_n  (arst_n_i),
        .cke    (cke_i),
        .clr    (tmo_clr),
        .en     (in_access),
        .expired(expired)
    );

    // Access sequencer; every output is registered and frozen while cke_i is low.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state          <= ST_IDLE;
            ch_q           <= '0;
            native_rdata_o <= '0;
            native_ready_o <= 1'b0;
            err_o          <= 1'b0;
            iob_avalid_o   <= '0;
            iob_addr_o     <= '0;
            iob_wdata_o    <= '0;
            iob_wstrb_o    <= '0;
        end else if (cke_i) begin
            case (state)
                ST_IDLE: begin
                    if (native_valid_i) begin
                        iob_addr_o  <= native_addr_i;
                        iob_wdata_o <= native_wdata_i;
                        iob_wstrb_o <= native_wstrb_i;
                        ch_q        <= addr_ch;
                        if (bad_ch) begin
                            state          <= ST_DONE;
                            native_ready_o <= 1'b1;
                            err_o          <= 1'b1;
                            native_rdata_o <= ERR_RDATA;
                        end else begin
                            state        <= ST_REQ;
                            iob_avalid_o <= addr_onehot;
                        end
                    end
                end
                ST_REQ: begin
                    if (sel_ready) begin
                        iob_avalid_o <= '0;
                        if (|iob_wstrb_o) begin
                            state          <= ST_DONE;
                            native_ready_o <= 1'b1;
                            native_rdata_o <= '0;
                        end else begin
                            state <= ST_RESP;
                        end
                    end else if (expired) begin
                        iob_avalid_o   <= '0;
                        state          <= ST_DONE;
                        native_ready_o <= 1'b1;
                        err_o          <= 1'b1;
                        native_rdata_o <= ERR_RDATA;
                    end
                end
                ST_RESP: begin
                    if (sel_rvalid) begin
                        state          <= ST_DONE;
                        native_ready_o <= 1'b1;
                        native_rdata_o <= sel_rdata;
                    end else if (expired) begin
                        state          <= ST_DONE;
                        native_ready_o <= 1'b1;
                        err_o          <= 1'b1;
                        native_rdata_o <= ERR_RDATA;
                    end
                end
                ST_DONE: begin
                    state          <= ST_IDLE;
                    native_ready_o <= 1'b0;
                    err_o          <= 1'b0;
                    native_rdata_o <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule
